// File: rtl/mem_bus_responder.sv
// Memory-side responder for the 16-bit CPU: word RAM, LED/switch I/O page, and an interval timer.
// Define MEMBUS_TIMER_EN to build the timer (TCOUNT/TCMP/TSTAT/TCTRL and timerIrq).
module mem_bus_responder #(
    parameter int RAM_DEPTH = 4096,
    parameter int LED_W     = 8,
    parameter int SW_W      = 8,
    parameter int PRESCALE  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [15:0]       outAddr,
    input  logic              memWrite,
    input  logic [15:0]       memWriteData,
    output logic [15:0]       memDataInbound,
    input  logic [SW_W-1:0]   switches,
    output logic [LED_W-1:0]  leds,
    output logic              timerIrq
);

    localparam int          AW        = $clog2(RAM_DEPTH);
    localparam logic [16:0] RAM_LIMIT = 17'(RAM_DEPTH);
    localparam logic [7:0]  A_LED     = 8'h00;
    localparam logic [7:0]  A_SW      = 8'h01;

    // Legal configurations elaborate nothing here; the condition records the parameter limits.
    if (PRESCALE < 1 || RAM_DEPTH > 'hFF00 || (RAM_DEPTH & (RAM_DEPTH - 1)) != 0) begin : gBadParams
    end

    logic [15:0]      ramMem [RAM_DEPTH];
    logic             ramHit;
    logic             ioHit;
    logic [7:0]       ioSel;
    logic [15:0]      readData;
    logic [LED_W-1:0] ledReg;
    logic [SW_W-1:0]  swSync1Reg;
    logic [SW_W-1:0]  swSync2Reg;

    // RAM_DEPTH never exceeds 0xFF00, so the RAM and the I/O page cannot overlap.
    assign ramHit = {1'b0, outAddr} < RAM_LIMIT;
    assign ioHit  = (outAddr[15:8] == 8'hFF);
    assign ioSel  = outAddr[7:0];

    always_ff @(posedge clk) begin
        if (memWrite && ramHit) begin
            ramMem[outAddr[AW-1:0]] <= memWriteData;
        end
    end

`ifdef MEMBUS_TIMER_EN
    localparam logic [7:0]    A_TCOUNT = 8'h02;
    localparam logic [7:0]    A_TCMP   = 8'h03;
    localparam logic [7:0]    A_TSTAT  = 8'h04;
    localparam logic [7:0]    A_TCTRL  = 8'h05;
    localparam int            PW       = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] PS_LAST  = PW'(PRESCALE - 1);

    logic [PW-1:0] prescaleReg;
    logic [15:0]   countReg;
    logic [15:0]   cmpReg;
    logic          enableReg;
    logic          flagReg;
    logic          tick;
    logic          match;
    logic          wrCount;
    logic          wrCmp;
    logic          wrCtrl;
    logic          rdStat;

    assign wrCount = memWrite && ioHit && (ioSel == A_TCOUNT);
    assign wrCmp   = memWrite && ioHit && (ioSel == A_TCMP);
    assign wrCtrl  = memWrite && ioHit && (ioSel == A_TCTRL);
    assign rdStat  = !memWrite && ioHit && (ioSel == A_TSTAT);
    assign tick    = enableReg && (prescaleReg == PS_LAST);
    assign match   = tick && (countReg == cmpReg);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prescaleReg <= '0;
            countReg    <= 16'h0000;
            cmpReg      <= 16'hFFFF;
            enableReg   <= 1'b0;
            flagReg     <= 1'b0;
        end else begin
            if (wrCmp) begin
                cmpReg <= memWriteData;
            end
            if (wrCtrl) begin
                enableReg <= memWriteData[0];
            end
            if (wrCtrl && memWriteData[0]) begin
                prescaleReg <= '0;
            end else if (enableReg) begin
                prescaleReg <= (prescaleReg == PS_LAST) ? '0 : prescaleReg + PW'(1);
            end
            // A CPU write to the count overrides whatever the tick would have done.
            if (wrCount) begin
                countReg <= memWriteData;
            end else if (match) begin
                countReg <= 16'h0000;
            end else if (tick) begin
                countReg <= countReg + 16'd1;
            end
            // A match on the same edge as a TSTAT read keeps the flag set.
            if (match) begin
                flagReg <= 1'b1;
            end else if (rdStat) begin
                flagReg <= 1'b0;
            end
        end
    end

    assign timerIrq = flagReg;
`else
    assign timerIrq = 1'b0;
`endif

    always_comb begin
        readData = 16'h0000;
        if (ramHit) begin
            readData = memWrite ? memWriteData : ramMem[outAddr[AW-1:0]];
        end else if (ioHit) begin
            case (ioSel)
                A_LED:    readData = 16'(ledReg);
                A_SW:     readData = 16'(swSync2Reg);
`ifdef MEMBUS_TIMER_EN
                A_TCOUNT: readData = countReg;
                A_TCMP:   readData = cmpReg;
                A_TSTAT:  readData = {15'b0, flagReg};
                A_TCTRL:  readData = {15'b0, enableReg};
`endif
                default:  readData = 16'h0000;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            memDataInbound <= 16'h0000;
            ledReg         <= '0;
            swSync1Reg     <= '0;
            swSync2Reg     <= '0;
        end else begin
            memDataInbound <= readData;
            swSync1Reg     <= switches;
            swSync2Reg     <= swSync1Reg;
            if (memWrite && ioHit && (ioSel == A_LED)) begin
                ledReg <= memWriteData[LED_W-1:0];
            end
        end
    end

    assign leds = ledReg;

endmodule

// File: tb/tb_mem_bus_responder.sv
// Bench for mem_bus_responder: directed accesses, a cycle-level reference model, and literal spot checks.
// Timer sequences are exercised only when MEMBUS_TIMER_EN is defined.
module tb_mem_bus_responder;

    localparam int RAM_DEPTH   = 4096;
    localparam int TB_PRESCALE = 1;
`ifdef MEMBUS_TIMER_EN
    localparam logic [15:0] RST_TCMP = 16'hFFFF;
`else
    localparam logic [15:0] RST_TCMP = 16'h0000;
`endif

    logic        clk;
    logic        reset;
    logic [15:0] outAddr;
    logic        memWrite;
    logic [15:0] memWriteData;
    logic [15:0] memDataInbound;
    logic [7:0]  switches;
    logic [7:0]  leds;
    logic        timerIrq;

    int checks = 0;
    int errors = 0;

    mem_bus_responder #(
        .RAM_DEPTH (RAM_DEPTH),
        .LED_W     (8),
        .SW_W      (8),
        .PRESCALE  (TB_PRESCALE)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .outAddr        (outAddr),
        .memWrite       (memWrite),
        .memWriteData   (memWriteData),
        .memDataInbound (memDataInbound),
        .switches       (switches),
        .leds           (leds),
        .timerIrq       (timerIrq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state: what the memory map holds according to the access rules.
    logic [15:0] mRam [RAM_DEPTH];
    bit          mRamValid [RAM_DEPTH];
    logic [7:0]  mLed;
    logic [7:0]  swHist[$];
    logic [15:0] mCount;
    logic [15:0] mCmp;
    bit          mEn;
    int          mPre;
    bit          mFlag;
    logic [15:0] expData;
    bit          expValid;
    bit          modelOn = 1'b0;

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%04h expected 0x%04h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        mLed     = 8'h00;
        swHist   = '{8'h00, 8'h00};
        mCount   = 16'h0000;
        mCmp     = 16'hFFFF;
        mEn      = 1'b0;
        mPre     = 0;
        mFlag    = 1'b0;
        expData  = 16'h0000;
        expValid = 1'b1;
    endtask

    task automatic modelStep();
        logic [15:0] a;
        logic [15:0] wd;
        logic        we;
        logic [15:0] rd;
        bit          ok;
        bit          tickNow;
        bit          hitNow;
        a  = outAddr;
        we = memWrite;
        wd = memWriteData;
        rd = 16'h0000;
        ok = 1'b1;
        // Read value is what the location held before this edge (RAM shows the write data).
        if (int'(a) < RAM_DEPTH) begin
            if (we) rd = wd;
            else if (mRamValid[int'(a)]) rd = mRam[int'(a)];
            else ok = 1'b0;
        end else begin
            case (a)
                16'hFF00: rd = {8'h00, mLed};
                16'hFF01: rd = {8'h00, swHist[1]};
`ifdef MEMBUS_TIMER_EN
                16'hFF02: rd = mCount;
                16'hFF03: rd = mCmp;
                16'hFF04: rd = {15'b0, mFlag};
                16'hFF05: rd = {15'b0, mEn};
`endif
                default:  rd = 16'h0000;
            endcase
        end
        expData  = rd;
        expValid = ok;
        if (we && int'(a) < RAM_DEPTH) begin
            mRam[int'(a)]      = wd;
            mRamValid[int'(a)] = 1'b1;
        end
        if (we && a == 16'hFF00) mLed = wd[7:0];
        swHist.push_front(switches);
        swHist = swHist[0:1];
`ifdef MEMBUS_TIMER_EN
        tickNow = mEn && (mPre == TB_PRESCALE - 1);
        hitNow  = tickNow && (mCount == mCmp);
        if (we && a == 16'hFF02) mCount = wd;
        else if (hitNow) mCount = 16'h0000;
        else if (tickNow) mCount = mCount + 16'd1;
        if (hitNow) mFlag = 1'b1;
        else if (!we && a == 16'hFF04) mFlag = 1'b0;
        if (we && a == 16'hFF05 && wd[0]) mPre = 0;
        else if (mEn) mPre = (mPre + 1) % TB_PRESCALE;
        if (we && a == 16'hFF05) mEn = wd[0];
        if (we && a == 16'hFF03) mCmp = wd;
`else
        tickNow = 1'b0;
        hitNow  = tickNow;
`endif
    endtask

    always @(posedge clk) begin
        if (reset && modelOn) modelStep();
    end

    always @(negedge clk) begin
        if (reset && modelOn) begin
            if (expValid) check("model_rdata", memDataInbound, expData);
            check("model_leds", {8'h00, leds}, {8'h00, mLed});
            check("model_irq", {15'b0, timerIrq}, {15'b0, mFlag});
        end
    end

    task automatic cycle(input logic [15:0] a, input logic w, input logic [15:0] d);
        outAddr      = a;
        memWrite     = w;
        memWriteData = d;
        @(posedge clk);
        #1;
        $display("txn addr=%04h we=%0d wdata=%04h -> rdata=%04h leds=%02h irq=%0d",
                 a, w, d, memDataInbound, leds, timerIrq);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "timeout");
    end

    logic [15:0] patAddr [4];
    logic [15:0] patData [4];

    initial begin
        patAddr = '{16'h0000, 16'h0FFF, 16'h0800, 16'h0123};
        patData = '{16'hFFFF, 16'h8001, 16'h5A5A, 16'h0000};
        for (int i = 0; i < RAM_DEPTH; i++) mRamValid[i] = 1'b0;
        reset        = 1'b0;
        outAddr      = 16'h0000;
        memWrite     = 1'b0;
        memWriteData = 16'h0000;
        switches     = 8'h00;
        modelReset();
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b1;
        #1;
        check("rst_rdata", memDataInbound, 16'h0000);
        check("rst_leds", {8'h00, leds}, 16'h0000);
        check("rst_irq", {15'b0, timerIrq}, 16'h0000);
        modelOn = 1'b1;
        @(posedge clk);
        #1;

        // RAM write-first and read-back
        cycle(16'h0010, 1'b1, 16'h1234);
        check("ram_write_first", memDataInbound, 16'h1234);
        cycle(16'h0010, 1'b0, 16'h0000);
        check("ram_readback", memDataInbound, 16'h1234);
        for (int i = 0; i < 4; i++) cycle(patAddr[i], 1'b1, patData[i]);
        for (int i = 0; i < 4; i++) begin
            cycle(patAddr[i], 1'b0, 16'h0000);
            check("ram_pattern", memDataInbound, patData[i]);
        end

        // LED register and unmapped space
        cycle(16'hFF00, 1'b1, 16'h00A5);
        check("led_write", {8'h00, leds}, 16'h00A5);
        cycle(16'hFF00, 1'b1, 16'hFFFF);
        cycle(16'hFF00, 1'b0, 16'h0000);
        check("led_read_narrow", memDataInbound, 16'h00FF);
        cycle(16'h2000, 1'b1, 16'hBEEF);
        cycle(16'h2000, 1'b0, 16'h0000);
        check("unmapped_2000", memDataInbound, 16'h0000);
        cycle(16'h1000, 1'b1, 16'hCAFE);
        cycle(16'h1000, 1'b0, 16'h0000);
        check("unmapped_depth", memDataInbound, 16'h0000);
        cycle(16'hFF07, 1'b0, 16'h0000);
        check("unmapped_ff07", memDataInbound, 16'h0000);

        // Switch synchronizer latency
        switches = 8'h3C;
        cycle(16'hFF01, 1'b0, 16'h0000);
        check("sw_edge1", memDataInbound, 16'h0000);
        cycle(16'hFF01, 1'b0, 16'h0000);
        check("sw_edge2", memDataInbound, 16'h0000);
        cycle(16'hFF01, 1'b1, 16'h00FF);
        check("sw_edge3", memDataInbound, 16'h003C);
        cycle(16'hFF01, 1'b0, 16'h0000);
        check("sw_write_ignored", memDataInbound, 16'h003C);

`ifdef MEMBUS_TIMER_EN
        // Timer: TCMP=3, enable, count 0,1,2,3,0
        cycle(16'hFF03, 1'b1, 16'h0003);
        cycle(16'hFF05, 1'b1, 16'h0001);
        for (int i = 0; i < 5; i++) begin
            cycle(16'hFF02, 1'b0, 16'h0000);
            check("tcount_seq", memDataInbound, (i == 4) ? 16'h0000 : 16'(i));
            check("tirq_seq", {15'b0, timerIrq}, (i >= 3) ? 16'h0001 : 16'h0000);
        end
        cycle(16'hFF04, 1'b0, 16'h0000);
        check("tstat_read", memDataInbound, 16'h0001);
        check("tstat_cleared", {15'b0, timerIrq}, 16'h0000);
        cycle(16'hFF00, 1'b0, 16'h0000);
        cycle(16'hFF04, 1'b0, 16'h0000);
        check("tstat_race_data", memDataInbound, 16'h0000);
        check("tstat_race_irq", {15'b0, timerIrq}, 16'h0001);
        cycle(16'hFF04, 1'b1, 16'h0000);
        check("tstat_write_ignored", {15'b0, timerIrq}, 16'h0001);
`endif

        // Set up count=2 with the timer enabled, then reset between edges
        cycle(16'hFF05, 1'b1, 16'h0000);
        cycle(16'hFF02, 1'b1, 16'h0001);
        cycle(16'hFF05, 1'b1, 16'h0001);
        cycle(16'h0010, 1'b0, 16'h0000);
`ifdef MEMBUS_TIMER_EN
        check("pre_reset_irq", {15'b0, timerIrq}, 16'h0001);
`endif
        memWrite = 1'b0;
        reset    = 1'b0;
        modelReset();
        #1;
        check("async_rdata", memDataInbound, 16'h0000);
        check("async_leds", {8'h00, leds}, 16'h0000);
        check("async_irq", {15'b0, timerIrq}, 16'h0000);
        #2;
        reset = 1'b1;
        cycle(16'hFF02, 1'b0, 16'h0000);
        cycle(16'hFF02, 1'b0, 16'h0000);
        check("post_rst_tcount", memDataInbound, 16'h0000);
        cycle(16'hFF03, 1'b0, 16'h0000);
        check("post_rst_tcmp", memDataInbound, RST_TCMP);
        cycle(16'hFF05, 1'b0, 16'h0000);
        check("post_rst_tctrl", memDataInbound, 16'h0000);
        cycle(16'h0010, 1'b0, 16'h0000);
        check("post_rst_ram", memDataInbound, 16'h1234);
        cycle(16'hFF00, 1'b0, 16'h0000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
